// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } serial_add_state_t;

  localparam int MAX_ADD_WIDTH = 64;

  // Counter must reach WIDTH-1 without wrapping; one spare bit keeps cnt+1 representable.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for bit_serial_adder; slave is the adder, master the producer/consumer side.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             busy;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout, busy
  );

endinterface

// File: rtl/full_adder.sv
// 1-bit combinational full adder; zero latency, no flow control.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder, one bit per clock through a single full_adder; out_valid rises WIDTH edges after accept.
// Accepts only when idle; result is held in DONE until out_ready, stalling the producer meanwhile.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bit_serial_adder_if.slave    bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  serial_add_state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic             accept;

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = (state == IDLE) && bus.in_valid;

  // New sum bits enter at the top so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_one
      assign sum_sh_nxt = fa_sum;
    end else begin : g_wide
      assign sum_sh_nxt = {fa_sum, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh   <= bus.A;
      b_sh   <= bus.B;
      carry  <= bus.Cin;
      cnt    <= '0;
      sum_sh <= '0;
    end else if (state == RUN) begin
      sum_sh <= sum_sh_nxt;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        sum_q  <= sum_sh_nxt;
        cout_q <= fa_cout;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;

endmodule
